// File: rtl/afifo_wr_txn_tap.sv
// Passive write-port monitor for the async FIFO write domain: captures accepted
// writes with sequence number and preceding stall count, plus saturating statistics.
module afifo_wr_txn_tap #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int CAP_DEPTH   = 16,
    parameter int SEQ_WIDTH   = 16,
    parameter int STALL_WIDTH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                         wclk,
    input  logic                         wrst,
    input  logic                         mon_en,
    input  logic                         clr,
    input  logic                         winc,
    input  logic                         wfull,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic                         txn_valid,
    input  logic                         txn_ready,
    output logic [DATA_WIDTH-1:0]        txn_data,
    output logic [SEQ_WIDTH-1:0]         txn_seq,
    output logic [STALL_WIDTH-1:0]       txn_stall,
    output logic [$clog2(CAP_DEPTH):0]   cap_level,
    output logic [CNT_WIDTH-1:0]         acc_cnt,
    output logic [CNT_WIDTH-1:0]         blk_cnt,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
    output logic                         ovf_sticky
);

    localparam int PTR_W = $clog2(CAP_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (CAP_DEPTH < 2 || (CAP_DEPTH & (CAP_DEPTH - 1)) != 0 || ADDR_WIDTH < 1) begin : g_bad_param
        $error("afifo_wr_txn_tap: CAP_DEPTH must be a power of 2 >= 2 and ADDR_WIDTH >= 1");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [STALL_WIDTH-1:0] sat_inc_stall(input logic [STALL_WIDTH-1:0] v);
        return (&v) ? v : v + STALL_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0]  data_mem  [CAP_DEPTH];
    logic [SEQ_WIDTH-1:0]   seq_mem   [CAP_DEPTH];
    logic [STALL_WIDTH-1:0] stall_mem [CAP_DEPTH];

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [SEQ_WIDTH-1:0]   seq_q;
    logic [STALL_WIDTH-1:0] stall_run;
    logic [CNT_WIDTH-1:0]   acc_q;
    logic [CNT_WIDTH-1:0]   blk_q;
    logic [CNT_WIDTH-1:0]   drop_q;
    logic                   ovf_q;

    logic acc_ev;
    logic blk_ev;
    logic pop;
    logic room;
    logic push;
    logic drop;

    // Event decode: clr suppresses every same-cycle event
    always_comb begin
        acc_ev = mon_en && winc && !wfull && !clr;
        blk_ev = mon_en && winc && wfull && !clr;
        pop    = (level != '0) && txn_ready && !clr;
        room   = (level < LVL_W'(CAP_DEPTH)) || pop;
        push   = acc_ev && room;
        drop   = acc_ev && !room;
    end

    // Capture storage carries data only, so it is left out of reset
    always_ff @(posedge wclk) begin
        if (push) begin
            data_mem[wr_ptr]  <= wdata;
            seq_mem[wr_ptr]   <= seq_q;
            stall_mem[wr_ptr] <= stall_run;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            seq_q     <= '0;
            stall_run <= '0;
            acc_q     <= '0;
            blk_q     <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            seq_q     <= '0;
            stall_run <= '0;
            acc_q     <= '0;
            blk_q     <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // Sequence advances on every accepted write, including drops
            if (acc_ev) begin
                seq_q     <= seq_q + SEQ_WIDTH'(1);
                stall_run <= '0;
                acc_q     <= sat_inc_cnt(acc_q);
            end else if (blk_ev) begin
                stall_run <= sat_inc_stall(stall_run);
            end
            if (blk_ev) blk_q <= sat_inc_cnt(blk_q);
            if (drop) begin
                drop_q <= sat_inc_cnt(drop_q);
                ovf_q  <= 1'b1;
            end
        end
    end

    // Head fields read as zero whenever the buffer is empty
    always_comb begin
        txn_valid  = (level != '0);
        txn_data   = txn_valid ? data_mem[rd_ptr]  : '0;
        txn_seq    = txn_valid ? seq_mem[rd_ptr]   : '0;
        txn_stall  = txn_valid ? stall_mem[rd_ptr] : '0;
        cap_level  = level;
        acc_cnt    = acc_q;
        blk_cnt    = blk_q;
        drop_cnt   = drop_q;
        ovf_sticky = ovf_q;
    end

endmodule

// File: tb/tb_afifo_wr_txn_tap.sv
// Directed bench for afifo_wr_txn_tap: default instance plus a 4-bit sequence instance.
module tb_afifo_wr_txn_tap;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        mon_en;
    logic        clr;
    logic        winc;
    logic        wfull;
    logic [31:0] wdata;
    logic        txn_ready;

    logic        txn_valid;
    logic [31:0] txn_data;
    logic [15:0] txn_seq;
    logic [7:0]  txn_stall;
    logic [4:0]  cap_level;
    logic [31:0] acc_cnt, blk_cnt, drop_cnt;
    logic        ovf_sticky;

    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_seq;
    logic [7:0]  s_stall;
    logic [4:0]  s_level;
    logic [31:0] s_acc, s_blk, s_drop;
    logic        s_ovf;

    int errors = 0;
    int checks = 0;

    always #5 wclk = ~wclk;

    afifo_wr_txn_tap dut (
        .wclk(wclk), .wrst(wrst), .mon_en(mon_en), .clr(clr), .winc(winc),
        .wfull(wfull), .wdata(wdata), .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_data(txn_data), .txn_seq(txn_seq), .txn_stall(txn_stall),
        .cap_level(cap_level), .acc_cnt(acc_cnt), .blk_cnt(blk_cnt),
        .drop_cnt(drop_cnt), .ovf_sticky(ovf_sticky)
    );

    afifo_wr_txn_tap #(.SEQ_WIDTH(4)) dut_s4 (
        .wclk(wclk), .wrst(wrst), .mon_en(mon_en), .clr(clr), .winc(winc),
        .wfull(wfull), .wdata(wdata), .txn_valid(s_valid), .txn_ready(txn_ready),
        .txn_data(s_data), .txn_seq(s_seq), .txn_stall(s_stall),
        .cap_level(s_level), .acc_cnt(s_acc), .blk_cnt(s_blk),
        .drop_cnt(s_drop), .ovf_sticky(s_ovf)
    );

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; winc = 1'b0; wfull = 1'b0; txn_ready = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1; mon_en = 1'b0; clr = 1'b0; winc = 1'b0; wfull = 1'b0;
        wdata = '0; txn_ready = 1'b0;
        step(); step();
        wrst = 1'b0;
        checks++; if (txn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", txn_valid); end
        checks++; if (cap_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", cap_level); end
        checks++; if (acc_cnt !== 32'd0 || blk_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", acc_cnt, blk_cnt, drop_cnt); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf_sticky); end
    endtask

    task automatic test_basic();
        mon_en = 1'b1;
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 32'hA0 + i;
            step();
        end
        winc = 1'b0;
        step();
        checks++; if (cap_level !== 5'd3) begin errors++; $display("FAIL basic_level got=%0d exp=3", cap_level); end
        checks++; if (txn_data !== 32'hA0) begin errors++; $display("FAIL basic_head got=%h exp=a0", txn_data); end
        checks++; if (txn_seq !== 16'd0) begin errors++; $display("FAIL basic_seq got=%0d exp=0", txn_seq); end
        checks++; if (acc_cnt !== 32'd3) begin errors++; $display("FAIL basic_acc got=%0d exp=3", acc_cnt); end
        txn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (txn_data !== 32'hA0 + i || txn_seq !== 16'(i)) begin
                errors++; $display("FAIL basic_drain%0d got=%h/%0d exp=%h/%0d", i, txn_data, txn_seq, 32'hA0 + i, i); end
            step();
        end
        txn_ready = 1'b0;
        checks++; if (txn_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%0b exp=0", txn_valid); end
    endtask

    task automatic test_stall();
        do_clr();
        winc = 1'b1; wfull = 1'b1;
        repeat (5) step();
        wfull = 1'b0; wdata = 32'hB0;
        step();
        wdata = 32'hB1;
        step();
        winc = 1'b0;
        checks++; if (blk_cnt !== 32'd5) begin errors++; $display("FAIL stall_blk got=%0d exp=5", blk_cnt); end
        checks++; if (cap_level !== 5'd2) begin errors++; $display("FAIL stall_level got=%0d exp=2", cap_level); end
        checks++; if (txn_data !== 32'hB0 || txn_stall !== 8'd5 || txn_seq !== 16'd0) begin
            errors++; $display("FAIL stall_first got=%h/%0d/%0d exp=b0/5/0", txn_data, txn_stall, txn_seq); end
        txn_ready = 1'b1;
        step();
        txn_ready = 1'b0;
        checks++; if (txn_data !== 32'hB1 || txn_stall !== 8'd0 || txn_seq !== 16'd1) begin
            errors++; $display("FAIL stall_next got=%h/%0d/%0d exp=b1/0/1", txn_data, txn_stall, txn_seq); end
        mon_en = 1'b0; winc = 1'b1;
        step(); step();
        wfull = 1'b1;
        step();
        winc = 1'b0; wfull = 1'b0;
        checks++; if (acc_cnt !== 32'd2 || blk_cnt !== 32'd5 || cap_level !== 5'd1) begin
            errors++; $display("FAIL monoff_counts got=%0d/%0d/%0d exp=2/5/1", acc_cnt, blk_cnt, cap_level); end
        txn_ready = 1'b1;
        step();
        txn_ready = 1'b0;
        checks++; if (cap_level !== 5'd0) begin errors++; $display("FAIL monoff_pop got=%0d exp=0", cap_level); end
        mon_en = 1'b1;
    endtask

    task automatic test_overflow();
        do_clr();
        winc = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wdata = 32'h100 + i;
            step();
        end
        winc = 1'b0;
        checks++; if (cap_level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", cap_level); end
        checks++; if (drop_cnt !== 32'd2 || ovf_sticky !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got=%0d/%0b exp=2/1", drop_cnt, ovf_sticky); end
        checks++; if (acc_cnt !== 32'd18) begin errors++; $display("FAIL ovf_acc got=%0d exp=18", acc_cnt); end
        winc = 1'b1; wdata = 32'h200; txn_ready = 1'b1;
        step();
        winc = 1'b0; txn_ready = 1'b0;
        checks++; if (cap_level !== 5'd16 || drop_cnt !== 32'd2) begin
            errors++; $display("FAIL full_pushpop got=%0d/%0d exp=16/2", cap_level, drop_cnt); end
        checks++; if (txn_seq !== 16'd1 || txn_data !== 32'h101) begin
            errors++; $display("FAIL full_head got=%0d/%h exp=1/101", txn_seq, txn_data); end
        txn_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            automatic logic [15:0] es = (k < 15) ? 16'(k + 1) : 16'd18;
            automatic logic [31:0] ed = (k < 15) ? 32'h101 + k : 32'h200;
            checks++; if (txn_seq !== es || txn_data !== ed) begin
                errors++; $display("FAIL ovf_drain%0d got=%0d/%h exp=%0d/%h", k, txn_seq, txn_data, es, ed); end
            step();
        end
        txn_ready = 1'b0;
        checks++; if (txn_valid !== 1'b0 || ovf_sticky !== 1'b1) begin
            errors++; $display("FAIL ovf_after got=%0b/%0b exp=0/1", txn_valid, ovf_sticky); end
    endtask

    task automatic test_seq_wrap();
        do_clr();
        txn_ready = 1'b1; winc = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wdata = 32'h300 + i;
            step();
            checks++; if (s_seq !== 4'(i % 16) || s_level !== 5'd1) begin
                errors++; $display("FAIL wrap%0d got=%0d/%0d exp=%0d/1", i, s_seq, s_level, i % 16); end
        end
        winc = 1'b0;
        step();
        txn_ready = 1'b0;
    endtask

    task automatic test_clr();
        do_clr();
        winc = 1'b1; wdata = 32'hC5;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0; winc = 1'b0;
        checks++; if (txn_valid !== 1'b0 || cap_level !== 5'd0 || txn_data !== 32'd0) begin
            errors++; $display("FAIL clr_buf got=%0b/%0d/%h exp=0/0/0", txn_valid, cap_level, txn_data); end
        checks++; if (acc_cnt !== 32'd0 || drop_cnt !== 32'd0 || ovf_sticky !== 1'b0) begin
            errors++; $display("FAIL clr_stats got=%0d/%0d/%0b exp=0/0/0", acc_cnt, drop_cnt, ovf_sticky); end
        winc = 1'b1; wdata = 32'hC0;
        step();
        winc = 1'b0;
        checks++; if (txn_data !== 32'hC0 || txn_seq !== 16'd0 || acc_cnt !== 32'd1) begin
            errors++; $display("FAIL clr_next got=%h/%0d/%0d exp=c0/0/1", txn_data, txn_seq, acc_cnt); end
    endtask

    task automatic test_reset_mid();
        winc = 1'b1; wfull = 1'b1;
        step();
        wfull = 1'b0; wdata = 32'hD1;
        step(); step();
        winc = 1'b0;
        #1 wrst = 1'b1;
        #1;
        checks++; if (txn_valid !== 1'b0 || cap_level !== 5'd0 || acc_cnt !== 32'd0 || blk_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got=%0b/%0d/%0d/%0d exp=0/0/0/0", txn_valid, cap_level, acc_cnt, blk_cnt); end
        #1 wrst = 1'b0;
        winc = 1'b1; wdata = 32'hD9;
        step();
        winc = 1'b0;
        checks++; if (txn_data !== 32'hD9 || txn_seq !== 16'd0 || txn_stall !== 8'd0 || cap_level !== 5'd1) begin
            errors++; $display("FAIL rstmid_next got=%h/%0d/%0d/%0d exp=d9/0/0/1", txn_data, txn_seq, txn_stall, cap_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_seq_wrap();
        test_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
